fft8_frame_ctrl: RTL and testbench
==================================

# fft8_frame_ctrl

Front-end sequencer that feeds the 8-point magnitude-spectrum FFT core. It collects a stream of signed 13-bit audio samples into ping-pong 8-sample frames and launches the core with a one-cycle start pulse. It tracks the core's busy handshake, then latches the 8 magnitude bins into a packed output with a one-cycle valid strobe. It sits between the audio sample source and the spectrum consumer and is the initiator side of the core's start/busy interface.

## Interface
- No parameters; frame length fixed at 8, sample/bin width fixed at 13 bits signed.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low; the FFT core's synchronous active-high reset is driven from ~rst_n at top level.
- s_valid  in  1  sample strobe; s_data accepted on each clock edge where it is high.
- s_data  in  13  signed sample, Q0.12.
- clr_overrun  in  1  clears the overrun flag.
- fft_start  out  1  one-cycle launch pulse to the core.
- fft_busy  in  1  core busy; core outputs are valid when low.
- fft_x0 … fft_x7  out  13 each  frame samples in natural order, driven from the launching bank.
- fft_o0 … fft_o7  in  13 each  core magnitude outputs.
- spec_valid  out  1  one-cycle strobe, spec_data is new.
- spec_data  out  104  bin k at [13k+12:13k]; held until the next capture.
- overrun  out  1  sticky; set when a sample is dropped.

## Operation
- Two banks, A and B, of 8×13-bit entries each, plus wr_bank, wr_idx[2:0], rd_bank, and full[1:0].
- Write side, on s_valid:
  - If full[wr_bank]=1, the sample is dropped and overrun is set.
  - Otherwise the sample is stored at bank[wr_bank][wr_idx] and wr_idx increments.
  - When wr_idx=7, full[wr_bank] is set, wr_bank toggles, and wr_idx wraps to 0.
- Read FSM states: IDLE, LAUNCH, WAIT_HI, WAIT_LO.
  - IDLE → LAUNCH when full[rd_bank]=1.
  - LAUNCH: fft_start=1 for exactly this cycle. Transitions to WAIT_HI unconditionally. On exit, full[rd_bank] is cleared and rd_bank toggles, because the core latches its inputs on the start cycle.
  - WAIT_HI → WAIT_LO when fft_busy=1. This is required because busy is still low in the cycle start is sampled.
  - WAIT_LO → IDLE when fft_busy=0. On the same edge, fft_o0..7 are registered into spec_data and spec_valid is set for one cycle.
- fft_x0..7 are a mux of bank[rd_bank], stable through LAUNCH.
- Banks are served strictly in fill order; frames are never reordered or merged.
- Simultaneous events:
  - A write completing one bank and a free of the other bank in the same cycle both take effect.
  - A sample arriving in the free-edge cycle of the bank it targets is dropped, because the full flag is still set at that edge.
  - overrun set and clr_overrun in the same cycle: set wins.

## Timing
- Reset values: fft_start=0, spec_valid=0, spec_data=0, overrun=0, fft_x*=0, state=IDLE, full=00, wr_idx=0, wr_bank=rd_bank=A.
- Reset mid-operation discards partial and full frames. The FSM returns to IDLE; no spec_valid is issued for an in-flight frame.
- The 8th sample accepted at edge E sets full at E. State enters LAUNCH at E+1, so fft_start is high for the cycle E+1..E+2.
- Capture: when fft_busy is sampled low at edge F in WAIT_LO, spec_valid and spec_data change at F and spec_valid falls at F+1.
- The block is latency-agnostic to the core and waits indefinitely in WAIT_HI/WAIT_LO.
- Sustained input with no drops requires core turnaround plus 2 cycles ≤ 8 sample periods.

## Configuration
- FFT_FRAME_HANN_EN defined:
  - Each sample is multiplied by a periodic Hann coefficient w[wr_idx] before storage. Coefficients are {0, 600, 2048, 3496, 4095, 3496, 2048, 600} (Q0.12).
  - stored = (s_data × w) >>> 12, using a 26-bit signed product and truncation. No saturation is needed.
  - This adds no latency; the multiply is combinational on the write path.
- FFT_FRAME_HANN_EN undefined: samples are stored unmodified; no multiplier is present.

## Test plan
- Basic frame:
  - Stimulus: 8 consecutive s_valid samples of 4095. Core stub raises busy 1 cycle after start, holds it 30 cycles, and presents o_k=k+1.
  - Response: one fft_start pulse at E+1 with fft_x0..7=4095. spec_valid pulses once, 1 edge after busy is sampled low, with spec_data bins = 1..8.
- Overrun:
  - Stimulus: 32 samples on back-to-back cycles while the stub holds busy 200 cycles.
  - Response: samples 25–32 dropped and overrun=1. Three spec_valid pulses follow, in order A, B, A. clr_overrun then sets overrun=0.
- Gapped input:
  - Stimulus: s_valid every 3rd cycle with s_data=k on the k-th strobe, k=0..7, plus junk s_data on idle cycles.
  - Response: fft_x0..7 = 0..7 exactly.
- Window, FFT_FRAME_HANN_EN defined:
  - Stimulus: 8×4095.
  - Response: fft_x = {0, 599, 2047, 3495, 4094, 3495, 2047, 599}.
  - Stimulus: 8×(−4096).
  - Response: x2 = −2048.
- Window, FFT_FRAME_HANN_EN undefined:
  - Stimulus: 8×4095.
  - Response: all fft_x = 4095.
- Reset in WAIT_LO:
  - Stimulus: rst_n low for 1 cycle mid-transform.
  - Response: all outputs at reset values immediately. No spec_valid occurs, and the next fft_start needs 8 fresh samples.

Source files
------------

// File: rtl/fft8_frame_ctrl.sv
// fft8_frame_ctrl: collects signed 13-bit samples into ping-pong 8-sample frames,
// launches the magnitude FFT core, and captures its 8 bins into spec_data.
// Optional build macro: FFT_FRAME_HANN_EN applies a periodic Hann window on the
// write path before storage.
module fft8_frame_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  input  logic [12:0]   s_data,
  input  logic          clr_overrun,
  output logic          fft_start,
  input  logic          fft_busy,
  output logic [12:0]   fft_x0,
  output logic [12:0]   fft_x1,
  output logic [12:0]   fft_x2,
  output logic [12:0]   fft_x3,
  output logic [12:0]   fft_x4,
  output logic [12:0]   fft_x5,
  output logic [12:0]   fft_x6,
  output logic [12:0]   fft_x7,
  input  logic [12:0]   fft_o0,
  input  logic [12:0]   fft_o1,
  input  logic [12:0]   fft_o2,
  input  logic [12:0]   fft_o3,
  input  logic [12:0]   fft_o4,
  input  logic [12:0]   fft_o5,
  input  logic [12:0]   fft_o6,
  input  logic [12:0]   fft_o7,
  output logic          spec_valid,
  output logic [103:0]  spec_data,
  output logic          overrun
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO} state_t;

  state_t       state, state_nx;
  logic [12:0]  bank [2][8];
  logic         wr_bank;
  logic         rd_bank;
  logic [2:0]   wr_idx;
  logic [1:0]   full;
  logic [12:0]  wr_val;
  logic         wr_en;
  logic         wr_drop;
  logic [1:0]   full_set;
  logic [1:0]   full_clr;

`ifdef FFT_FRAME_HANN_EN
  logic [12:0]         win;
  logic signed [25:0]  prod;

  // Hann coefficient for the slot being written (Q0.12)
  always_comb begin
    win = '0;
    case (wr_idx)
      3'd0: win = 13'd0;
      3'd1: win = 13'd600;
      3'd2: win = 13'd2048;
      3'd3: win = 13'd3496;
      3'd4: win = 13'd4095;
      3'd5: win = 13'd3496;
      3'd6: win = 13'd2048;
      3'd7: win = 13'd600;
      default: win = '0;
    endcase
  end

  // Coefficient is non-negative, so it is zero-extended before the signed multiply
  assign prod   = $signed(s_data) * $signed({1'b0, win});
  assign wr_val = prod[24:12];
`else
  assign wr_val = s_data;
`endif

  assign wr_en    = s_valid && !full[wr_bank];
  assign wr_drop  = s_valid &&  full[wr_bank];
  assign full_set = (wr_en && (wr_idx == 3'd7)) ? (2'b01 << wr_bank) : 2'b00;
  assign full_clr = (state == LAUNCH) ? (2'b01 << rd_bank) : 2'b00;

  // Write side: store accepted samples and advance the fill pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned i = 0; i < 8; i++)
          bank[b][i] <= '0;
      wr_idx  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_en) begin
      bank[wr_bank][wr_idx] <= wr_val;
      wr_idx                <= wr_idx + 3'd1;
      if (wr_idx == 3'd7)
        wr_bank <= ~wr_bank;
    end
  end

  // Full flags: fill and free always target different banks, so both may apply at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      full <= '0;
    else
      full <= (full | full_set) & ~full_clr;
  end

  // Sticky overrun; a new drop takes precedence over the clear request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overrun <= 1'b0;
    else if (wr_drop)
      overrun <= 1'b1;
    else if (clr_overrun)
      overrun <= 1'b0;
  end

  // Read FSM state register and read-bank pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == LAUNCH)
        rd_bank <= ~rd_bank;
    end
  end

  // Read FSM next state and launch pulse
  always_comb begin
    state_nx  = state;
    fft_start = 1'b0;
    case (state)
      IDLE:    if (full[rd_bank]) state_nx = LAUNCH;
      LAUNCH: begin
        fft_start = 1'b1;
        state_nx  = WAIT_HI;
      end
      WAIT_HI: if (fft_busy)  state_nx = WAIT_LO;
      WAIT_LO: if (!fft_busy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Capture the core's bins when busy drops and strobe spec_valid for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_valid <= 1'b0;
      spec_data  <= '0;
    end else if ((state == WAIT_LO) && !fft_busy) begin
      spec_valid <= 1'b1;
      spec_data  <= {fft_o7, fft_o6, fft_o5, fft_o4, fft_o3, fft_o2, fft_o1, fft_o0};
    end else begin
      spec_valid <= 1'b0;
    end
  end

  assign fft_x0 = bank[rd_bank][0];
  assign fft_x1 = bank[rd_bank][1];
  assign fft_x2 = bank[rd_bank][2];
  assign fft_x3 = bank[rd_bank][3];
  assign fft_x4 = bank[rd_bank][4];
  assign fft_x5 = bank[rd_bank][5];
  assign fft_x6 = bank[rd_bank][6];
  assign fft_x7 = bank[rd_bank][7];

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Testbench for fft8_frame_ctrl: behavioural core stub plus a frame-level
// reference model (sample stream -> 8-sample frames -> expected bins).
module tb_fft8_frame_ctrl;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [12:0]   s_data = '0;
  logic          clr_overrun = 1'b0;
  logic          fft_start;
  logic          fft_busy;
  logic [103:0]  xbus;
  logic [103:0]  o_bus;
  logic          spec_valid;
  logic [103:0]  spec_data;
  logic          overrun;

  fft8_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
    .clr_overrun(clr_overrun), .fft_start(fft_start), .fft_busy(fft_busy),
    .fft_x0(xbus[12:0]),   .fft_x1(xbus[25:13]),  .fft_x2(xbus[38:26]),
    .fft_x3(xbus[51:39]),  .fft_x4(xbus[64:52]),  .fft_x5(xbus[77:65]),
    .fft_x6(xbus[90:78]),  .fft_x7(xbus[103:91]),
    .fft_o0(o_bus[12:0]),  .fft_o1(o_bus[25:13]), .fft_o2(o_bus[38:26]),
    .fft_o3(o_bus[51:39]), .fft_o4(o_bus[64:52]), .fft_o5(o_bus[77:65]),
    .fft_o6(o_bus[90:78]), .fft_o7(o_bus[103:91]),
    .spec_valid(spec_valid), .spec_data(spec_data), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Core stub configuration
  int  stub_mode = 0;
  int  hold_max  = 30;
  bit  hold_rand = 1'b0;
  logic [103:0] cap;
  int  cnt;

  // Bins the stub presents for a captured frame
  function automatic logic [103:0] core_fn(input logic [103:0] x, input int mode);
    logic [103:0] r;
    logic [12:0]  v;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (mode == 0) v = 13'(k + 1);
      else           v = 13'(int'(x[13*k +: 13]) + 5 * (k + 1));
      r[13*k +: 13] = v;
    end
    return r;
  endfunction

  // Behavioural core: busy rises on the start edge, stays high for the hold count
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fft_busy <= 1'b0;
      o_bus    <= '0;
      cap      <= '0;
      cnt      <= 0;
    end else if (fft_start) begin
      cap      <= xbus;
      fft_busy <= 1'b1;
      cnt      <= hold_rand ? int'($urandom_range(1, hold_max)) : hold_max;
    end else if (fft_busy) begin
      if (cnt <= 1) begin
        fft_busy <= 1'b0;
        o_bus    <= core_fn(cap, stub_mode);
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  // Reference model state
  int win_tab[8] = '{0, 600, 2048, 3496, 4095, 3496, 2048, 600};
  logic [103:0] xq[$];
  logic [103:0] sq[$];
  logic [103:0] acc = '0;
  int pos = 0;
  int cyc = 0;
  int fall_cyc = -100;
  bit prev_busy = 1'b0;
  bit prev_start = 1'b0;
  int n_start = 0;
  logic [103:0] last_x = '0;

  function automatic logic [12:0] store_val(input int s, input int idx);
    int p;
`ifdef FFT_FRAME_HANN_EN
    p = (s * win_tab[idx]) >>> 12;
`else
    p = s + 0 * idx;
`endif
    return p[12:0];
  endfunction

  task automatic chk(input string tag, input logic [103:0] obs, input logic [103:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input logic [12:0] d);
    int s;
    s = int'($signed(d));
    acc[13*pos +: 13] = store_val(s, pos);
    pos++;
    if (pos == 8) begin
      xq.push_back(acc);
      sq.push_back(core_fn(acc, stub_mode));
      pos = 0;
      acc = '0;
    end
  endtask

  // One clock: advance past the edge, then check launch/capture events
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (prev_busy && !fft_busy) fall_cyc = cyc;
    if (fft_start) begin
      n_start++;
      last_x = xbus;
      chk("start_width", prev_start, 1'b0);
      if (xq.size() == 0) chk("start_unexpected", fft_start, 1'b0);
      else chk("fft_x", xbus, xq.pop_front());
    end
    if (spec_valid) begin
      chk("capture_latency", cyc - fall_cyc, 1);
      if (sq.size() == 0) chk("spec_unexpected", spec_valid, 1'b0);
      else chk("spec_data", spec_data, sq.pop_front());
    end
    prev_busy  = fft_busy;
    prev_start = fft_start;
  endtask

  task automatic send(input logic [12:0] d, input bit v, input bit accept);
    s_valid = v;
    s_data  = d;
    if (v && accept) model_accept(d);
    tick();
    s_valid = 1'b0;
    s_data  = 13'($urandom);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((xq.size() != 0 || sq.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 104'(xq.size() + sq.size()), '0);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_fft_start", fft_start, 1'b0);
    chk("rst_spec_valid", spec_valid, 1'b0);
    chk("rst_spec_data", spec_data, '0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_fft_x", xbus, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    xq.delete();
    sq.delete();
    pos = 0;
    acc = '0;
    prev_busy = 1'b0;
    prev_start = 1'b0;
  endtask

  initial begin
    int st;
    logic [103:0] exp_x;

    // Power-on reset
    #2;
    do_reset();
    repeat (2) tick();

    // Basic frame: 8 x 4095, start exactly one edge after the 8th sample
    stub_mode = 0; hold_max = 30; hold_rand = 1'b0;
    for (int i = 0; i < 7; i++) send(13'd4095, 1'b1, 1'b1);
    send(13'd4095, 1'b1, 1'b1);
    chk("start_at_E", fft_start, 1'b0);
    tick();
    chk("start_at_E1", fft_start, 1'b1);
    drain(300);
`ifdef FFT_FRAME_HANN_EN
    exp_x = {13'd599, 13'd2047, 13'd3495, 13'd4094, 13'd3495, 13'd2047, 13'd599, 13'd0};
`else
    exp_x = {8{13'd4095}};
`endif
    chk("basic_x_const", last_x, exp_x);

    // Full-scale negative frame
    for (int i = 0; i < 8; i++) send(13'h1000, 1'b1, 1'b1);
    drain(300);
`ifdef FFT_FRAME_HANN_EN
    chk("neg_x2", last_x[38:26], 13'h1800);
`else
    chk("neg_x2", last_x[38:26], 13'h1000);
`endif

    // Gapped input with junk on idle cycles
    for (int k = 0; k < 8; k++) begin
      send(13'(k), 1'b1, 1'b1);
      send(13'($urandom), 1'b0, 1'b0);
      send(13'($urandom), 1'b0, 1'b0);
    end
    drain(300);
`ifndef FFT_FRAME_HANN_EN
    chk("gapped_x_const", last_x, {13'd7, 13'd6, 13'd5, 13'd4, 13'd3, 13'd2, 13'd1, 13'd0});
`endif

    // Overrun: 32 back-to-back samples against a slow core; the last 8 are dropped
    chk("overrun_pre", overrun, 1'b0);
    stub_mode = 1; hold_max = 200;
    for (int i = 0; i < 32; i++) send(13'($urandom), 1'b1, i < 24);
    chk("overrun_set", overrun, 1'b1);
    st = n_start;
    drain(2000);
    chk("overrun_frames", 104'(n_start - st), 104'(2));
    chk("overrun_sticky", overrun, 1'b1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("overrun_clr", overrun, 1'b0);

    // Reset while the core is busy: in-flight frame is abandoned
    stub_mode = 0; hold_max = 30;
    for (int i = 0; i < 8; i++) send(13'($urandom), 1'b1, 1'b1);
    repeat (10) tick();
    chk("mid_busy", fft_busy, 1'b1);
    do_reset();
    repeat (50) tick();
    st = n_start;
    for (int i = 0; i < 7; i++) send(13'($urandom), 1'b1, 1'b1);
    repeat (5) tick();
    chk("no_start_after_7", 104'(n_start - st), '0);
    send(13'($urandom), 1'b1, 1'b1);
    drain(300);
    chk("start_after_8", 104'(n_start - st), 104'(1));

    // Randomized stream against a fast core (no drops expected)
    stub_mode = 1; hold_max = 4; hold_rand = 1'b1;
    for (int i = 0; i < 400; i++)
      send(13'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
    drain(500);
    chk("random_no_overrun", overrun, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL timeout vectors=%0d miscompares=%0d", n_vec, n_fail);
    $fatal(1, "timeout");
  end

endmodule
